// File: rtl/ldl_period_meter_if.sv
// Result channel of the period meter: valid/ready handshake plus overflow
// flag and the one-cycle drop strobe.
interface ldl_period_meter_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] period;
    logic             overflow;
    logic             drop;

    modport master (
        output out_valid,
        output period,
        output overflow,
        output drop,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  period,
        input  overflow,
        input  drop,
        output out_ready
    );
endinterface

// File: rtl/ldl_period_meter.sv
// Measures clk cycles between consecutive active edges of an asynchronous
// pulse input and reports each interval over a valid/ready result channel.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | en low, counter cleared, no measurement
// S_ARM     | waiting for the first edge; no result on that edge
// S_MEASURE | counting since the previous edge; each edge emits a result
module ldl_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    input  logic [WIDTH-1:0]     timeout,
    output logic                 busy,
    ldl_period_meter_if.master   res
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE
    } state_t;

    localparam logic             IDLE_LVL = (EDGE != 0);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   strobe;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic                   emit;
    logic [WIDTH-1:0]       emit_period;
    logic                   emit_ovf;

    // Synchronizer and edge history run regardless of en so an enable
    // never sees a stale level as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            hist_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe = (sync_q[SYNC_STAGES-1] != hist_q) &&
                    (sync_q[SYNC_STAGES-1] != IDLE_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        emit        = 1'b0;
        emit_period = cnt_q;
        emit_ovf    = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (strobe) begin
                        state_d = S_MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    // A strobe landing on the timeout cycle is a real period.
                    if (strobe) begin
                        emit     = 1'b1;
                        emit_ovf = (cnt_q == CNT_MAX);
                        cnt_d    = CNT_ONE;
                    end else if ((timeout != '0) && (cnt_q == timeout)) begin
                        emit        = 1'b1;
                        emit_period = timeout;
                        emit_ovf    = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_ARM;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Result register: a held result is never overwritten; a competing
    // result is dropped unless the held one transfers in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.out_valid <= 1'b0;
            res.period    <= '0;
            res.overflow  <= 1'b0;
            res.drop      <= 1'b0;
        end else begin
            res.drop <= 1'b0;
            if (emit) begin
                if (!res.out_valid || res.out_ready) begin
                    res.out_valid <= 1'b1;
                    res.period    <= emit_period;
                    res.overflow  <= emit_ovf;
                end else begin
                    res.drop <= 1'b1;
                end
            end else if (res.out_valid && res.out_ready) begin
                res.out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q == S_MEASURE);

endmodule

// File: tb/tb_ldl_period_meter.sv
// Directed bench for ldl_period_meter: a 16-bit instance for most scenarios
// and a 4-bit instance for counter saturation, both fed the same din/en.
module tb_ldl_period_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        din;
    logic        ready;
    logic [15:0] timeout;
    logic [3:0]  timeout4;
    logic        busy;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    ldl_period_meter_if #(.WIDTH(16)) bus16 ();
    ldl_period_meter_if #(.WIDTH(4))  bus4 ();

    assign bus16.out_ready = ready;
    assign bus4.out_ready  = ready;

    ldl_period_meter #(.WIDTH(16), .SYNC_STAGES(2), .EDGE(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .din     (din),
        .timeout (timeout),
        .busy    (busy),
        .res     (bus16)
    );

    ldl_period_meter #(.WIDTH(4), .SYNC_STAGES(2), .EDGE(0)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .din     (din),
        .timeout (timeout4),
        .busy    (busy4),
        .res     (bus4)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rising edge on din, then check the result slot three clocks later
    // (two sync stages plus the result register) and idle out the gap.
    // mode 0: no result; 1: new result; 2: held result + drop;
    // 3: like 1 but out_ready is raised in the result cycle.
    task automatic edge_chk(input int gap, input int mode, input int sel,
                            input logic [15:0] exp_p, input logic exp_o, input string tag);
        logic        v;
        logic [15:0] p;
        logic        o;
        logic        d;
        din = 1'b1;
        tick(1);
        din = 1'b0;
        tick(1);
        if (mode == 3) ready = 1'b1;
        tick(1);
        v = sel ? bus4.out_valid : bus16.out_valid;
        p = sel ? {12'h000, bus4.period} : bus16.period;
        o = sel ? bus4.overflow : bus16.overflow;
        d = sel ? bus4.drop : bus16.drop;
        if (mode == 0) begin
            chk({tag, "_novalid"}, 32'(v), 32'd0);
        end else begin
            chk({tag, "_valid"}, 32'(v), 32'd1);
            chk({tag, "_period"}, 32'(p), 32'(exp_p));
            chk({tag, "_ovf"}, 32'(o), 32'(exp_o));
            chk({tag, "_drop"}, 32'(d), (mode == 2) ? 32'd1 : 32'd0);
        end
        if (mode == 2) begin
            tick(1);
            chk({tag, "_drop_end"}, 32'(bus16.drop), 32'd0);
            tick(gap - 4);
        end else begin
            tick(gap - 3);
        end
    endtask

    task automatic restart(input logic [15:0] tmo);
        en    = 1'b0;
        din   = 1'b0;
        ready = 1'b1;
        tick(3);
        timeout = tmo;
        en      = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        din      = 1'b0;
        ready    = 1'b1;
        timeout  = 16'd0;
        timeout4 = 4'd0;
        tick(3);
        chk("rst_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_period", 32'(bus16.period), 32'd0);
        chk("rst_ovf", 32'(bus16.overflow), 32'd0);
        chk("rst_drop", 32'(bus16.drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Steady 10-cycle strobes, no timeout
        restart(16'd0);
        edge_chk(10, 0, 0, 16'd0, 1'b0, "p10_first");
        chk("p10_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) edge_chk(10, 1, 0, 16'd10, 1'b0, "p10");

        // Timeout after one edge, then a 7-cycle pair
        restart(16'd20);
        edge_chk(10, 0, 0, 16'd0, 1'b0, "tmo_first");
        chk("tmo_busy_mid", 32'(busy), 32'd1);
        tick(13);
        chk("tmo_valid", 32'(bus16.out_valid), 32'd1);
        chk("tmo_period", 32'(bus16.period), 32'd20);
        chk("tmo_ovf", 32'(bus16.overflow), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick(17);
        chk("tmo_idle_valid", 32'(bus16.out_valid), 32'd0);
        edge_chk(7, 0, 0, 16'd0, 1'b0, "p7_first");
        edge_chk(7, 1, 0, 16'd7, 1'b0, "p7");

        // Edge lands exactly on the timeout cycle
        restart(16'd20);
        edge_chk(20, 0, 0, 16'd0, 1'b0, "tie_first");
        edge_chk(20, 1, 0, 16'd20, 1'b0, "tie");
        chk("tie_busy", 32'(busy), 32'd1);
        edge_chk(20, 1, 0, 16'd20, 1'b0, "tie2");

        // 4-bit saturation
        restart(16'd0);
        edge_chk(30, 0, 1, 16'd0, 1'b0, "sat_first");
        edge_chk(5, 1, 1, 16'd15, 1'b1, "sat");
        edge_chk(5, 1, 1, 16'd5, 1'b0, "sat_p5");
        edge_chk(5, 1, 1, 16'd5, 1'b0, "sat_p5b");

        // Backpressure: hold, drops, then load on transfer cycle
        restart(16'd0);
        edge_chk(6, 0, 0, 16'd0, 1'b0, "bp_first");
        ready = 1'b0;
        edge_chk(8, 1, 0, 16'd6, 1'b0, "bp_load");
        edge_chk(7, 2, 0, 16'd6, 1'b0, "bp_drop1");
        edge_chk(9, 2, 0, 16'd6, 1'b0, "bp_drop2");
        edge_chk(6, 3, 0, 16'd9, 1'b0, "bp_xfer");
        chk("bp_cleared", 32'(bus16.out_valid), 32'd0);

        // en drop mid-measurement, then async reset with a held result
        restart(16'd0);
        edge_chk(6, 0, 0, 16'd0, 1'b0, "en_first");
        en = 1'b0;
        tick(1);
        chk("en_busy", 32'(busy), 32'd0);
        tick(2);
        en = 1'b1;
        tick(1);
        edge_chk(6, 0, 0, 16'd0, 1'b0, "en_rearm");
        edge_chk(6, 1, 0, 16'd6, 1'b0, "en_p6");
        ready = 1'b0;
        edge_chk(6, 1, 0, 16'd6, 1'b0, "hold_p6");
        chk("pre_rst_valid", 32'(bus16.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus16.out_valid), 32'd0);
        chk("arst_period", 32'(bus16.period), 32'd0);
        chk("arst_ovf", 32'(bus16.overflow), 32'd0);
        chk("arst_drop", 32'(bus16.drop), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldl_period_meter.md
Name: ldl_period_meter

Overview:
- Measures the clk-cycle interval between consecutive active edges of an asynchronous pulse input.
- Receive-side companion to the library wrap counters and tick generators: it checks or measures periodic strobes produced elsewhere.
- Results are delivered on a valid/ready interface, with timeout and overflow reporting.

Parameters:
- WIDTH, 16, width of the period counter and result; 2..32.
- SYNC_STAGES, 2, number of input synchronizer flops; 2..4.
- EDGE, 0, active edge: 0 = rising, 1 = falling.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  measurement enable.
- din  in  1  asynchronous pulse input.
- timeout  in  WIDTH  max cycles to wait for the next edge; 0 disables timeout.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- period  out  WIDTH  measured interval in clk cycles.
- overflow  out  1  result is a timeout or saturation, not a true period.
- drop  out  1  one-cycle pulse: a result was discarded due to backpressure.
- busy  out  1  state is MEASURE.

Behaviour:
- Reset values:
  - out_valid=0, period=0, overflow=0, drop=0, busy=0, cnt=0, state IDLE.
  - Synchronizer and edge-history flops reset to the inactive level (EDGE=0 -> 0, EDGE=1 -> 1).
- Edge detect:
  - din passes through SYNC_STAGES flops, then a history flop.
  - The strobe is combinational: (last sync stage != history) AND new level is active.
  - The synchronizer and history flops always run, independent of en.
  - A din already at the active level when reset is released produces one strobe.
- States:
  - IDLE: en=0. cnt=0, no measurement. en=1 -> ARM.
  - ARM: waiting for the first edge. strobe -> MEASURE with cnt<=1; no result is produced.
  - MEASURE:
    - No strobe: cnt<=cnt+1, saturating at 2^WIDTH-1.
    - strobe: emit result period=cnt, overflow=(cnt==2^WIDTH-1); cnt<=1; stay in MEASURE.
- Result meaning: cnt equals the cycles elapsed since the previous strobe, so strobes P cycles apart report period=P. Synchronizer latency cancels out.
- Timeout (timeout!=0): in MEASURE, if cnt==timeout and there is no strobe that cycle:
  - emit period=timeout, overflow=1; cnt<=0; go to ARM.
  - If a strobe coincides with cnt==timeout, the strobe wins: normal result period=timeout, overflow=0.
- Saturation (timeout==0): cnt sticks at all-ones; the next strobe reports period=all-ones, overflow=1.
- en deassert: from any state go to IDLE next cycle with cnt<=0. A partial measurement is discarded. A pending output is kept and the handshake stays live.
- Result register and handshake:
  - A result is emitted in the strobe/timeout cycle and is visible (out_valid=1) on the next clock edge.
  - Transfer happens on out_valid&&out_ready.
  - period and overflow are held stable while out_valid=1 and out_ready=0.
  - New result while out_valid=1 and out_ready=0: new result discarded, drop=1 for one cycle, held result unchanged.
  - New result in the same cycle as a transfer: new result loads, out_valid stays 1, no drop.
  - Transfer with no new result: out_valid<=0. period and overflow keep their last value.
- Width rule: all counter compares are unsigned at WIDTH; timeout > 2^WIDTH-1 is not representable.
- rst_n asserted mid-operation: all state returns to reset values immediately. A pending result is lost; no drop pulse.
- busy = (state==MEASURE).

Test Plan:
1. WIDTH=16, timeout=0, en=1; din rising edges every 10 cycles, out_ready=1 -> first edge gives no result; each later edge gives out_valid with period=10, overflow=0; drop never asserted.
2. timeout=20; one edge, then din idle for 40 cycles -> one result period=20, overflow=1, busy falls; the next two edges 7 cycles apart give period=7.
3. timeout=20; edges exactly 20 cycles apart -> period=20, overflow=0, busy stays 1 (strobe beats timeout).
4. WIDTH=4, timeout=0; edges 30 cycles apart -> period=15, overflow=1; edges 5 apart afterwards -> period=5, overflow=0.
5. Edges every 6 cycles, out_ready=0 for 20 cycles -> first result held stable, drop pulses once per later edge; raise out_ready in a result cycle -> the newer result loads with no drop.
6. en dropped mid-MEASURE for 3 cycles, then raised -> IDLE, busy=0; the first edge after re-enable gives no result. Assert rst_n=0 while out_valid=1 -> all outputs go to 0 immediately.
